// File: rtl/max7219_chain.sv
// Continuous refresh driver for a daisy-chain of MAX7219 LED controllers.
// It holds a write-only SPI shifter and a register-row sequencer: init rows, then digit rows repeated forever.
module max7219_chain #(
   parameter int NUM_DEV       = 2,
   parameter int DIGITS        = 8,
   parameter int CLK_DIV       = 16,
   parameter int POR_CYCLES    = 1048576,
   parameter int REINIT_PASSES = 4096
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_DEV*DIGITS*4-1:0]   display_value,
   input  logic [NUM_DEV*DIGITS-1:0]     dp,
   input  logic [3:0]                    intensity,
   output logic                          din,
   output logic                          sck,
   output logic                          load,
   output logic                          busy_init,
   output logic                          pass_done
);

   localparam int TOTAL_BITS = NUM_DEV * 16;
   localparam int BIT_W      = $clog2(TOTAL_BITS);
   localparam int PH_W       = $clog2(CLK_DIV);
   localparam int POR_W      = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
   localparam int PASS_W     = (REINIT_PASSES > 1) ? $clog2(REINIT_PASSES) : 1;

   localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(TOTAL_BITS - 1);
   localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(CLK_DIV - 1);
   localparam logic [PH_W-1:0]   PH_HALF    = PH_W'(CLK_DIV / 2);
   localparam logic [POR_W-1:0]  POR_LAST   = POR_W'(POR_CYCLES - 1);
   localparam logic [PASS_W-1:0] PASS_LAST  = (REINIT_PASSES == 0) ? '0 : PASS_W'(REINIT_PASSES - 1);
   localparam logic [3:0]        DIG_LAST   = 4'(DIGITS);
   localparam logic [7:0]        SCAN_LIMIT = 8'(DIGITS - 1);

   typedef enum logic [2:0] {
      S_POR,
      S_INIT_ROW,
      S_PASS_START,
      S_REFRESH_ROW,
      S_SHIFT,
      S_LATCH,
      S_PASS_END
   } state_t;

   typedef enum logic [1:0] {
      ROW_INIT,
      ROW_INT,
      ROW_DIGIT
   } row_t;

   state_t                        state_reg, state_next;
   row_t                          row_reg, row_next;
   logic [2:0]                    init_idx_reg, init_idx_next;
   logic [3:0]                    digit_reg, digit_next;
   logic [BIT_W-1:0]              bit_cnt_reg, bit_cnt_next;
   logic [PH_W-1:0]               phase_reg, phase_next;
   logic [POR_W-1:0]              por_cnt_reg, por_cnt_next;
   logic [PASS_W-1:0]             pass_cnt_reg, pass_cnt_next;
   logic [TOTAL_BITS-1:0]         shift_reg, shift_next;
   logic [NUM_DEV*DIGITS*4-1:0]   value_snap_reg, value_snap_next;
   logic [NUM_DEV*DIGITS-1:0]     dp_snap_reg, dp_snap_next;
   logic [3:0]                    last_int_reg, last_int_next;
   logic                          busy_init_reg, busy_init_next;
   logic                          pass_done_reg, pass_done_next;
   logic                          din_reg, din_next;
   logic                          sck_reg, sck_next;
   logic                          load_reg, load_next;

   logic [11:0]                   init_word;
   logic [TOTAL_BITS-1:0]         init_frame;
   logic [TOTAL_BITS-1:0]         int_frame;
   logic [TOTAL_BITS-1:0]         refresh_frame;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'h7E;
         4'h1:    s = 7'h30;
         4'h2:    s = 7'h6D;
         4'h3:    s = 7'h79;
         4'h4:    s = 7'h33;
         4'h5:    s = 7'h5B;
         4'h6:    s = 7'h5F;
         4'h7:    s = 7'h70;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h7B;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h1F;
         4'hC:    s = 7'h4E;
         4'hD:    s = 7'h3D;
         4'hE:    s = 7'h4F;
         default: s = 7'h47;
      endcase
      return s;
   endfunction

   // {addr, data} of each init row; every device receives the same word
   always_comb begin
      init_word = 12'hC00;
      case (init_idx_reg)
         3'd0:    init_word = 12'hC00;
         3'd1:    init_word = 12'hF00;
         3'd2:    init_word = {4'hB, SCAN_LIMIT};
         3'd3:    init_word = 12'h900;
         3'd4:    init_word = {4'hA, 4'h0, intensity};
         default: init_word = 12'hC01;
      endcase
   end

   assign init_frame = {NUM_DEV{{4'h0, init_word}}};
   assign int_frame  = {NUM_DEV{{8'h0A, 4'h0, intensity}}};

   // Device k sits at frame slot k, so the farthest device occupies the MSBs and is shifted first
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DEV; gi++) begin : g_dev
         logic [7:0] dev_data;
         always_comb begin
            dev_data = 8'h00;
            for (int j = 0; j < DIGITS; j++) begin
               if (digit_reg == 4'(j + 1)) begin
                  dev_data = {dp_snap_reg[gi*DIGITS + j],
                              seg7(value_snap_reg[4*(gi*DIGITS + j) +: 4])};
               end
            end
         end
         assign refresh_frame[16*gi +: 16] = {4'h0, digit_reg, dev_data};
      end
   endgenerate

   always_comb begin
      state_next      = state_reg;
      row_next        = row_reg;
      init_idx_next   = init_idx_reg;
      digit_next      = digit_reg;
      bit_cnt_next    = bit_cnt_reg;
      phase_next      = phase_reg;
      por_cnt_next    = por_cnt_reg;
      pass_cnt_next   = pass_cnt_reg;
      shift_next      = shift_reg;
      value_snap_next = value_snap_reg;
      dp_snap_next    = dp_snap_reg;
      last_int_next   = last_int_reg;
      busy_init_next  = busy_init_reg;

      case (state_reg)
         S_POR: begin
            if (por_cnt_reg == POR_LAST) begin
               state_next    = S_INIT_ROW;
               init_idx_next = 3'd0;
            end else begin
               por_cnt_next = por_cnt_reg + 1'b1;
            end
         end
         S_INIT_ROW: begin
            shift_next   = init_frame;
            row_next     = ROW_INIT;
            bit_cnt_next = '0;
            phase_next   = '0;
            state_next   = S_SHIFT;
            if (init_idx_reg == 3'd4) begin
               last_int_next = intensity;
            end
         end
         S_PASS_START: begin
            value_snap_next = display_value;
            dp_snap_next    = dp;
            digit_next      = 4'd1;
            if (intensity != last_int_reg) begin
               shift_next    = int_frame;
               row_next      = ROW_INT;
               last_int_next = intensity;
               bit_cnt_next  = '0;
               phase_next    = '0;
               state_next    = S_SHIFT;
            end else begin
               state_next = S_REFRESH_ROW;
            end
         end
         S_REFRESH_ROW: begin
            shift_next   = refresh_frame;
            row_next     = ROW_DIGIT;
            bit_cnt_next = '0;
            phase_next   = '0;
            state_next   = S_SHIFT;
         end
         S_SHIFT: begin
            if (phase_reg == PH_LAST) begin
               phase_next = '0;
               if (bit_cnt_reg == BIT_LAST) begin
                  state_next = S_LATCH;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  shift_next   = {shift_reg[TOTAL_BITS-2:0], 1'b0};
               end
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         S_LATCH: begin
            if (phase_reg != PH_LAST) begin
               phase_next = phase_reg + 1'b1;
            end else begin
               phase_next = '0;
               case (row_reg)
                  ROW_INIT: begin
                     if (init_idx_reg == 3'd5) begin
                        busy_init_next = 1'b0;
                        state_next     = S_PASS_START;
                     end else begin
                        init_idx_next = init_idx_reg + 1'b1;
                        state_next    = S_INIT_ROW;
                     end
                  end
                  ROW_INT: begin
                     state_next = S_REFRESH_ROW;
                  end
                  default: begin
                     if (digit_reg == DIG_LAST) begin
                        state_next = S_PASS_END;
                     end else begin
                        digit_next = digit_reg + 1'b1;
                        state_next = S_REFRESH_ROW;
                     end
                  end
               endcase
            end
         end
         S_PASS_END: begin
            if (REINIT_PASSES != 0 && pass_cnt_reg == PASS_LAST) begin
               pass_cnt_next = '0;
               init_idx_next = 3'd0;
               state_next    = S_INIT_ROW;
            end else begin
               if (pass_cnt_reg != '1) begin
                  pass_cnt_next = pass_cnt_reg + 1'b1;
               end
               state_next = S_PASS_START;
            end
         end
         default: begin
            state_next = S_POR;
         end
      endcase

      // Pins are decoded from the upcoming state so they switch on the same edge as the sequencer
      din_next       = 1'b0;
      sck_next       = 1'b0;
      load_next      = 1'b1;
      pass_done_next = (state_next == S_PASS_END);
      if (state_next == S_SHIFT) begin
         load_next = 1'b0;
         din_next  = shift_next[TOTAL_BITS-1];
         sck_next  = (phase_next >= PH_HALF);
      end else if (state_next == S_LATCH) begin
         load_next = (phase_next >= PH_HALF);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_POR;
         row_reg        <= ROW_INIT;
         init_idx_reg   <= '0;
         digit_reg      <= 4'd1;
         bit_cnt_reg    <= '0;
         phase_reg      <= '0;
         por_cnt_reg    <= '0;
         pass_cnt_reg   <= '0;
         shift_reg      <= '0;
         value_snap_reg <= '0;
         dp_snap_reg    <= '0;
         last_int_reg   <= '0;
         busy_init_reg  <= 1'b1;
         pass_done_reg  <= 1'b0;
         din_reg        <= 1'b0;
         sck_reg        <= 1'b0;
         load_reg       <= 1'b1;
      end else begin
         state_reg      <= state_next;
         row_reg        <= row_next;
         init_idx_reg   <= init_idx_next;
         digit_reg      <= digit_next;
         bit_cnt_reg    <= bit_cnt_next;
         phase_reg      <= phase_next;
         por_cnt_reg    <= por_cnt_next;
         pass_cnt_reg   <= pass_cnt_next;
         shift_reg      <= shift_next;
         value_snap_reg <= value_snap_next;
         dp_snap_reg    <= dp_snap_next;
         last_int_reg   <= last_int_next;
         busy_init_reg  <= busy_init_next;
         pass_done_reg  <= pass_done_next;
         din_reg        <= din_next;
         sck_reg        <= sck_next;
         load_reg       <= load_next;
      end
   end

   assign din       = din_reg;
   assign sck       = sck_reg;
   assign load      = load_reg;
   assign busy_init = busy_init_reg;
   assign pass_done = pass_done_reg;

endmodule
